// File: rtl/uart_frame_bridge_pkg.sv
// Shared defaults and TX serialiser state encoding
// for the UART byte-to-frame bridge.
package uart_frame_bridge_pkg;

  localparam int FRAME_BYTES_DEF  = 8;
  localparam int IDLE_TIMEOUT_DEF = 100000;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_frame_bridge_result_fifo.sv
// Synchronous result FIFO; pointers carry one extra wrap bit
// so full and empty are told apart without a counter.
module result_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i && !full_o) wr_d = wr_q + 1'b1;
    if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_frame_bridge.sv
// Assembles UART bytes into solver frames and serialises
// queued solver results back out as bytes.
module uart_frame_bridge
  import uart_frame_bridge_pkg::*;
#(
  parameter int FRAME_BYTES  = FRAME_BYTES_DEF,
  parameter int RESULT_DEPTH = 4,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter bit MSB_FIRST    = 1'b1,
  localparam int W = 8 * FRAME_BYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_byte_valid,
  input  logic [7:0]   rx_byte,
  output logic [W-1:0] data_value,
  output logic         data_valid,
  input  logic         data_ready,
  input  logic         result_valid,
  input  logic [W-1:0] result_value,
  output logic [7:0]   tx_byte,
  output logic         tx_byte_valid,
  input  logic         tx_byte_ready,
  output logic         rx_overflow,
  output logic         tx_overflow,
  output logic         resync
);

  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam int TW = (IDLE_TIMEOUT > 0) ?
                      $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST  = CW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] TLAST = TW'(IDLE_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  sh_q, sh_d;
  logic [TW-1:0] tmr_q;
  logic [W-1:0]  dval_q;
  logic          dv_q, rx_ovf_q;
  logic          last_byte, tmo;

  assign sh_d = MSB_FIRST ?
    ((sh_q << 8) | W'(rx_byte)) :
    ((sh_q >> 8) | (W'(rx_byte) << (W - 8)));

  assign last_byte = rx_byte_valid && (cnt_q == LAST);
  // An arriving byte always beats an expiring timer.
  assign tmo = (IDLE_TIMEOUT != 0) && !reset &&
               (cnt_q != '0) && !rx_byte_valid &&
               (tmr_q == TLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      sh_q     <= '0;
      tmr_q    <= '0;
      dval_q   <= '0;
      dv_q     <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (rx_byte_valid || tmo || cnt_q == '0) tmr_q <= '0;
      else tmr_q <= tmr_q + TW'(1);

      if (last_byte || tmo) begin
        cnt_q <= '0;
        sh_q  <= '0;
      end else if (rx_byte_valid) begin
        cnt_q <= cnt_q + CW'(1);
        sh_q  <= sh_d;
      end

      if (last_byte) begin
        if (!dv_q || data_ready) begin
          dval_q <= sh_d;
          dv_q   <= 1'b1;
        end else begin
          rx_ovf_q <= 1'b1;
        end
      end else if (dv_q && data_ready) begin
        dv_q <= 1'b0;
      end
    end
  end

  assign data_value  = dval_q;
  assign data_valid  = dv_q;
  assign rx_overflow = rx_ovf_q;
  assign resync      = tmo;

  logic          res_prev_q, tx_ovf_q;
  logic          push_req, f_full, f_empty, f_pop;
  logic [W-1:0]  f_head;
  tx_state_e     st_q;
  logic [W-1:0]  tx_sh_q;
  logic [CW-1:0] idx_q;
  logic          txv_q;

  assign push_req = result_valid && !res_prev_q;
  assign f_pop    = (st_q == TX_IDLE) && !f_empty;

  result_fifo #(
    .W     (W),
    .DEPTH (RESULT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (f_pop),
    .data_i  (result_value),
    .full_o  (f_full),
    .empty_o (f_empty),
    .head_o  (f_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      res_prev_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      res_prev_q <= result_valid;
      if (push_req && f_full) tx_ovf_q <= 1'b1;
    end
  end

  // Current byte always sits at the wire end of tx_sh_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= TX_IDLE;
      tx_sh_q <= '0;
      idx_q   <= '0;
      txv_q   <= 1'b0;
    end else begin
      unique case (st_q)
        TX_IDLE: begin
          if (!f_empty) begin
            tx_sh_q <= f_head;
            idx_q   <= '0;
            txv_q   <= 1'b1;
            st_q    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_byte_ready) begin
            if (idx_q == LAST) begin
              txv_q <= 1'b0;
              st_q  <= TX_IDLE;
            end else begin
              idx_q   <= idx_q + CW'(1);
              tx_sh_q <= MSB_FIRST ? (tx_sh_q << 8) :
                                     (tx_sh_q >> 8);
            end
          end
        end
      endcase
    end
  end

  assign tx_byte       = MSB_FIRST ? tx_sh_q[W-1 -: 8] :
                                     tx_sh_q[7:0];
  assign tx_byte_valid = txv_q;
  assign tx_overflow   = tx_ovf_q;

endmodule

// File: tb/tb_uart_frame_bridge.sv
// Scoreboard bench for uart_frame_bridge: an 8-byte MSB-first
// instance and a 2-byte LSB-first instance.
module tb_uart_frame_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // u0: 8 bytes, MSB first, timeout 50
  logic        rbv0, dv0, dr0, resv0, txv0, txr0;
  logic        rxo0, txo0, rs0;
  logic [7:0]  rb0, txb0;
  logic [63:0] dval0, resval0;

  // u1: 2 bytes, LSB first
  logic        rbv1, dv1, dr1, resv1, txv1, txr1;
  logic        rxo1, txo1, rs1;
  logic [7:0]  rb1, txb1;
  logic [15:0] dval1, resval1;

  uart_frame_bridge #(
    .FRAME_BYTES (8), .RESULT_DEPTH (4),
    .IDLE_TIMEOUT (50), .MSB_FIRST (1'b1)
  ) u0 (
    .clk (clk), .reset (rst),
    .rx_byte_valid (rbv0), .rx_byte (rb0),
    .data_value (dval0), .data_valid (dv0),
    .data_ready (dr0), .result_valid (resv0),
    .result_value (resval0), .tx_byte (txb0),
    .tx_byte_valid (txv0), .tx_byte_ready (txr0),
    .rx_overflow (rxo0), .tx_overflow (txo0),
    .resync (rs0)
  );

  uart_frame_bridge #(
    .FRAME_BYTES (2), .RESULT_DEPTH (4),
    .IDLE_TIMEOUT (50), .MSB_FIRST (1'b0)
  ) u1 (
    .clk (clk), .reset (rst),
    .rx_byte_valid (rbv1), .rx_byte (rb1),
    .data_value (dval1), .data_valid (dv1),
    .data_ready (dr1), .result_valid (resv1),
    .result_value (resval1), .tx_byte (txb1),
    .tx_byte_valid (txv1), .tx_byte_ready (txr1),
    .rx_overflow (rxo1), .tx_overflow (txo1),
    .resync (rs1)
  );

  logic [63:0] exp_d0[$];
  logic [7:0]  exp_t0[$];
  logic [15:0] exp_d1[$];
  logic [7:0]  exp_t1[$];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm,
                       input logic [127:0] act);
    checks++;
    failures++;
    $display("FAIL %s unexpected got=%0h want=none", nm, act);
  endtask

  always @(negedge clk) begin
    if (!rst && dv0 && dr0) begin
      if (exp_d0.size() == 0) extra("data0", dval0);
      else chk("data0", dval0, exp_d0.pop_front());
    end
    if (!rst && txv0 && txr0) begin
      if (exp_t0.size() == 0) extra("tx0", txb0);
      else chk("tx0", txb0, exp_t0.pop_front());
    end
    if (!rst && dv1 && dr1) begin
      if (exp_d1.size() == 0) extra("data1", dval1);
      else chk("data1", dval1, exp_d1.pop_front());
    end
    if (!rst && txv1 && txr1) begin
      if (exp_t1.size() == 0) extra("tx1", txb1);
      else chk("tx1", txb1, exp_t1.pop_front());
    end
  end

  task automatic send0(input logic [7:0] b);
    rb0 = b; rbv0 = 1'b1;
    @(posedge clk); #1;
    rbv0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    rb1 = b; rbv1 = 1'b1;
    @(posedge clk); #1;
    rbv1 = 1'b0;
  endtask

  task automatic pulse0(input logic [63:0] v);
    resval0 = v; resv0 = 1'b1;
    @(posedge clk); #1;
    resv0 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, cnt;
    rst = 1'b1;
    rbv0 = 0; rb0 = 0; dr0 = 0; resv0 = 0;
    resval0 = 0; txr0 = 0;
    rbv1 = 0; rb1 = 0; dr1 = 0; resv1 = 0;
    resval1 = 0; txr1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dval0", dval0, 0);
    chk("rst_flags0", {dv0, txv0, rxo0, txo0, rs0}, 0);
    chk("rst_txb0", txb0, 0);
    chk("rst_all1", {dval1, dv1, txb1, txv1, rxo1, txo1, rs1}, 0);
    rst = 1'b0;

    // Frame in, ready high
    dr0 = 1'b1;
    exp_d0.push_back(64'h0102030405060708);
    for (int i = 1; i <= 8; i++) send0(8'(i));
    chk("dv_after_last", dv0, 1);
    @(posedge clk); #1;
    chk("dv_drop", dv0, 0);

    // Backpressure: second frame dropped
    dr0 = 1'b0;
    exp_d0.push_back(64'h1112131415161718);
    for (int i = 0; i < 8; i++) send0(8'h11 + 8'(i));
    for (int i = 0; i < 8; i++) send0(8'h22 + 8'(i));
    chk("bp_valid", dv0, 1);
    chk("bp_lead", dval0[63:56], 8'h11);
    chk("rx_ovf", rxo0, 1);
    dr0 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", dv0, 0);

    // Partial frame, timeout resync
    send0(8'h33); send0(8'h34); send0(8'h35);
    first = 0; cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rs0) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("resync_count", cnt, 1);
    chk("resync_cycle", first, 50);
    #1;
    exp_d0.push_back(64'hAAABACADAEAFB0B1);
    for (int i = 0; i < 8; i++) send0(8'hAA + 8'(i));
    repeat (3) @(posedge clk);
    #1;

    // Result held high: one push only
    txr0 = 1'b1;
    exp_t0.push_back(8'hDE); exp_t0.push_back(8'hAD);
    exp_t0.push_back(8'hBE); exp_t0.push_back(8'hEF);
    exp_t0.push_back(8'h00); exp_t0.push_back(8'h00);
    exp_t0.push_back(8'h00); exp_t0.push_back(8'h01);
    resval0 = 64'hDEADBEEF00000001;
    resv0 = 1'b1;
    @(posedge clk); #1;
    chk("txv_n1", txv0, 0);
    @(posedge clk); #1;
    chk("txv_n2", txv0, 1);
    repeat (8) @(posedge clk);
    #1;
    resv0 = 1'b0;
    for (int i = 0; i < 100 && exp_t0.size() != 0; i++)
      @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("tx_drain1", exp_t0.size(), 0);

    // FIFO overflow with transmitter stalled
    txr0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        exp_t0.push_back(8'hC0); exp_t0.push_back(8'hDE);
        for (int z = 0; z < 5; z++) exp_t0.push_back(8'h00);
        exp_t0.push_back(8'(k));
      end
      pulse0(64'hC0DE_0000_0000_0000 | 64'(k));
    end
    chk("tx_ovf", txo0, 1);
    chk("stall_valid", txv0, 1);
    chk("stall_byte", txb0, 8'hC0);
    txr0 = 1'b1;
    for (int i = 0; i < 300 && exp_t0.size() != 0; i++)
      @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
    chk("tx_drain2", exp_t0.size(), 0);

    // LSB-first 2-byte instance
    dr1 = 1'b1;
    txr1 = 1'b1;
    exp_d1.push_back(16'h1234);
    send1(8'h34); send1(8'h12);
    chk("dv1", dv1, 1);
    exp_t1.push_back(8'hEF); exp_t1.push_back(8'hBE);
    resval1 = 16'hBEEF;
    resv1 = 1'b1;
    @(posedge clk); #1;
    resv1 = 1'b0;
    for (int i = 0; i < 50 && exp_t1.size() != 0; i++)
      @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("tx1_drain", exp_t1.size(), 0);
    chk("d0_drain", exp_d0.size(), 0);
    chk("d1_drain", exp_d1.size(), 0);
    chk("ovf1", {rxo1, txo1}, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
